// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ENABLE/DISABLE levels, stored entry width, entry layout, pc alignment helper.
package instruction_fetch_queue_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // One stored entry: 32-bit pc, 32-bit instruction and 1 fault bit.
    localparam int FETCH_ENTRY_WIDTH = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        fault;
    } fetch_entry_t;

    // A fetch address is faulty when it is not word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle for the instruction fetch queue.
// Latency: n/a (wiring only).
// Backpressure: fetch_ready stalls fetch; decode_ready stalls the head entry.
// master: fetch unit / decode / redirect logic. slave: the queue itself.
interface instruction_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) ();

    logic              flush;
    logic              fetch_valid;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_instruction;
    logic              fetch_ready;
    logic              decode_valid;
    logic [31:0]       decode_pc;
    logic [31:0]       decode_instruction;
    logic              decode_fault;
    logic              decode_ready;
    logic [PTR_W:0]    occupancy;

    modport master (
        output flush, fetch_valid, fetch_pc, fetch_instruction, decode_ready,
        input  fetch_ready, decode_valid, decode_pc, decode_instruction,
               decode_fault, occupancy
    );

    modport slave (
        input  flush, fetch_valid, fetch_pc, fetch_instruction, decode_ready,
        output fetch_ready, decode_valid, decode_pc, decode_instruction,
               decode_fault, occupancy
    );

endinterface

// File: rtl/instruction_fetch_queue_storage.sv
// Register array holding queued fetch entries, cleared by async reset.
// Latency: write lands on the clock edge; read port is combinational.
// Backpressure: none here; the caller only writes when a slot is free.
// Ports: clk, reset (async, active low), wr_en_i/wr_ptr_i/wr_data_i, rd_ptr_i/rd_data_o.
module fetch_queue_storage
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [PTR_W-1:0]             wr_ptr_i,
    input  logic [FETCH_ENTRY_WIDTH-1:0] wr_data_i,
    input  logic [PTR_W-1:0]             rd_ptr_i,
    output logic [FETCH_ENTRY_WIDTH-1:0] rd_data_o
);

    logic [FETCH_ENTRY_WIDTH-1:0] mem_q [DEPTH];

    // Cleared on reset so the head fields read as zero, never X, when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Buffers {pc, instruction, fault} between fetch and decode; flush drops all entries.
// Latency: a pushed entry is visible at decode one cycle later (no empty bypass).
// Backpressure: fetch_ready = not full, from registered count only; decode_ready pops the head.
// Ports: clk, reset (async, active low), bus (slave modport of instruction_fetch_queue_if).
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_queue_if.slave   bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic         push;
    logic         pop;
    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    // Full/empty come only from the count; the pointers alone are ambiguous
    // when they are equal. Keeping fetch_ready off decode_ready means a
    // full queue will not accept a push even if decode pops that cycle.
    assign bus.fetch_ready  = (count_q != FULL_CNT);
    assign bus.decode_valid = (count_q != '0);
    assign bus.occupancy    = count_q;

    assign push = bus.fetch_valid  && bus.fetch_ready  && !bus.flush;
    assign pop  = bus.decode_valid && bus.decode_ready && !bus.flush;

    assign wr_entry = '{
        pc:          bus.fetch_pc,
        instruction: bus.fetch_instruction,
        fault:       pc_misaligned(bus.fetch_pc)
    };

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign bus.decode_pc          = rd_entry.pc;
    assign bus.decode_instruction = rd_entry.instruction;
    assign bus.decode_fault       = rd_entry.fault;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: vector table, corner sequences, random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents as a plain ordered list.
    fetch_entry_t model_q[$];

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        dr;
        logic        fl;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        int          exp_occ;
        logic        exp_ready;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("model fetch_ready",  32'(bus.fetch_ready),  32'(model_q.size() != DEPTH));
        check("model decode_valid", 32'(bus.decode_valid), 32'(model_q.size() != 0));
        check("model occupancy",    32'(bus.occupancy),    32'(model_q.size()));
        if (model_q.size() != 0) begin
            check("model decode_pc",          bus.decode_pc,          model_q[0].pc);
            check("model decode_instruction", bus.decode_instruction, model_q[0].instruction);
            check("model decode_fault",       32'(bus.decode_fault),  32'(model_q[0].fault));
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, update
    // the model with the same rules, then compare at the next negedge.
    task automatic tick(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl);
        bit do_push;
        bit do_pop;
        bus.fetch_valid       = fv;
        bus.fetch_pc          = pc;
        bus.fetch_instruction = ins;
        bus.decode_ready      = dr;
        bus.flush             = fl;
        do_push = fv && (model_q.size() < DEPTH) && !fl;
        do_pop  = (model_q.size() > 0) && dr && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  model_q.delete(0);
            if (do_push) model_q.push_back('{pc: pc, instruction: ins, fault: (pc[1:0] != 2'b00)});
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " decode_valid"},       32'(bus.decode_valid), 32'd0);
        check({tag, " decode_pc"},          bus.decode_pc,          32'd0);
        check({tag, " decode_instruction"}, bus.decode_instruction, 32'd0);
        check({tag, " decode_fault"},       32'(bus.decode_fault),  32'd0);
        check({tag, " occupancy"},          32'(bus.occupancy),     32'd0);
        check({tag, " fetch_ready"},        32'(bus.fetch_ready),   32'd1);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] rpc;
        logic        rfv, rdr, rfl;

        //           fv  pc            ins           dr  fl  valid exp_pc        exp_ins       occ rdy flt
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0040_0093, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'h0080_0113, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 3, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h00C0_0193, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 4, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 4, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0040_0093, 3, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0080_0113, 2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 32'h00C0_0193, 1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h00C0_0193, 1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 1'b0};

        bus.fetch_valid       = 1'b0;
        bus.fetch_pc          = 32'h0;
        bus.fetch_instruction = 32'h0;
        bus.decode_ready      = 1'b0;
        bus.flush             = 1'b0;

        // Reset state, both while held and just after release.
        repeat (2) @(negedge clk);
        check_cleared("in reset");
        reset = 1'b1;
        @(negedge clk);
        check_cleared("after reset");

        // Directed table: fill to full, rejected 5th push, in-order drain, fault bit.
        foreach (vecs[i]) begin
            tick(vecs[i].fv, vecs[i].pc, vecs[i].ins, vecs[i].dr, vecs[i].fl);
            check($sformatf("vec%0d decode_valid", i), 32'(bus.decode_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d occupancy", i),    32'(bus.occupancy),    32'(vecs[i].exp_occ));
            check($sformatf("vec%0d fetch_ready", i),  32'(bus.fetch_ready),  32'(vecs[i].exp_ready));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d decode_pc", i),    bus.decode_pc,          vecs[i].exp_pc);
                check($sformatf("vec%0d decode_ins", i),   bus.decode_instruction, vecs[i].exp_ins);
                check($sformatf("vec%0d decode_fault", i), 32'(bus.decode_fault),  32'(vecs[i].exp_fault));
            end
        end

        // Steady occupancy of 2 with simultaneous push/pop across pointer wrap.
        tick(1'b1, 32'h0000_0200, 32'hA000_0200, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0204, 32'hA000_0204, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 32'h0000_0208 + 32'(4 * k), 32'hA000_0208 + 32'(4 * k), 1'b1, 1'b0);
            check("steady occupancy", 32'(bus.occupancy), 32'd2);
            check("steady head pc",   bus.decode_pc,      32'h0000_0204 + 32'(4 * k));
        end

        // Flush at occupancy 3 with a push in the same cycle.
        tick(1'b1, 32'h0000_0230, 32'hA000_0230, 1'b0, 1'b0);
        check("pre-flush occupancy", 32'(bus.occupancy), 32'd3);
        tick(1'b1, 32'h0000_BAD0, 32'hBAD0_BAD0, 1'b0, 1'b1);
        check("flush occupancy",    32'(bus.occupancy),    32'd0);
        check("flush decode_valid", 32'(bus.decode_valid), 32'd0);
        check("flush fetch_ready",  32'(bus.fetch_ready),  32'd1);
        tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("post-flush still empty", 32'(bus.decode_valid), 32'd0);
        tick(1'b1, 32'h0000_0300, 32'hA000_0300, 1'b0, 1'b0);
        check("post-flush head pc", bus.decode_pc, 32'h0000_0300);

        // Asynchronous reset mid-cycle at occupancy 3.
        tick(1'b1, 32'h0000_0304, 32'hA000_0304, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0308, 32'hA000_0308, 1'b0, 1'b0);
        check("pre-reset occupancy", 32'(bus.occupancy), 32'd3);
        #2 reset = 1'b0;
        #1 check_cleared("async reset");
        model_q.delete();
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 32'h0000_0400, 32'hA000_0400, 1'b0, 1'b0);
        check("post-reset decode_valid", 32'(bus.decode_valid), 32'd1);
        check("post-reset decode_pc",    bus.decode_pc,         32'h0000_0400);
        check("post-reset occupancy",    32'(bus.occupancy),    32'd1);

        // Random traffic against the model; bias alternates between filling and draining.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            rpc = {rnd[31:2], 2'b00};
            if ($urandom_range(0, 7) == 0) rpc[1:0] = rnd[1:0];
            if (((i / 64) % 2) == 0) begin
                rfv = ($urandom_range(0, 3) != 0);
                rdr = ($urandom_range(0, 3) == 0);
            end else begin
                rfv = ($urandom_range(0, 3) == 0);
                rdr = ($urandom_range(0, 3) != 0);
            end
            rfl = ($urandom_range(0, 31) == 0);
            tick(rfv, rpc, $urandom(), rdr, rfl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
